instr_fetch_estu: RTL and testbench

Instruction fetch stage directly upstream of the ESTU control FSM. It holds the program counter and issues reads to the synchronous instruction memory on each `fetch_instr` pulse. It registers the returned word and decodes the control flags the FSM consumes: `valid_instr`, `last_instr`, `use_v` and `v_gen_id`. The decoded fields stay stable until the next fetch or PC clear, so the FSM can sample them throughout CHECK_V and RUN.

---
 rtl/instr_fetch_estu_if.sv | 22 ++
 rtl/instr_fetch_estu.sv | 129 ++++++++++++
 tb/tb_instr_fetch_estu.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_estu_if.sv
// Instruction memory read port between the fetch stage (master) and the
// synchronous instruction memory (slave).
interface instr_fetch_estu_if #(
   parameter int INSTR_W = 32,
   parameter int ADDR_W  = 8
) ();
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_rd_en;
   logic [INSTR_W-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_rd_en,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_rd_en,
      output mem_rdata
   );
endinterface

// File: rtl/instr_fetch_estu.sv
// Fetch stage feeding the ESTU control FSM: issues one instruction memory read
// per fetch request, holds the returned word and exposes its decoded flags.
module instr_fetch_estu #(
   parameter int INSTR_W = 32,
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 1   // legal range 1..4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fetch_instr,
   input  logic                 clr_pc,
   instr_fetch_estu_if.master   mem,
   output logic                 valid_instr,
   output logic                 last_instr,
   output logic                 use_v,
   output logic                 v_gen_id,
   output logic [INSTR_W-4:0]   instr_payload,
   output logic [ADDR_W-1:0]    pc,
   output logic                 pc_wrap
);

   localparam int               CNT_W    = 3;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t             state_reg;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt_reg;
   logic [ADDR_W-1:0]  pc_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic               rd_en_reg;
   logic               wrap_reg;
   logic [INSTR_W-1:0] instr_reg;
   logic               issue_read;
   logic               capture;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // clr_pc outranks everything, so a fetch arriving with it never issues a read.
   always_comb begin
      state_next = state_reg;
      issue_read = 1'b0;
      capture    = 1'b0;
      if (clr_pc) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (fetch_instr) begin
                  state_next = READ;
                  issue_read = 1'b1;
               end
            end
            READ: begin
               if (cnt_reg == '0) begin
                  state_next = HOLD;
                  capture    = 1'b1;
               end
            end
            HOLD: begin
               if (fetch_instr) begin
                  state_next = READ;
                  issue_read = 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg   <= '0;
         pc_reg    <= '0;
         addr_reg  <= '0;
         rd_en_reg <= 1'b0;
         wrap_reg  <= 1'b0;
         instr_reg <= '0;
      end else begin
         rd_en_reg <= issue_read;
         if (clr_pc) begin
            // Dropping the counter discards whatever the memory returns later.
            pc_reg   <= '0;
            wrap_reg <= 1'b0;
            cnt_reg  <= '0;
         end else begin
            if (issue_read) begin
               addr_reg <= pc_reg;
               cnt_reg  <= LAT_LOAD;
            end else if (state_reg == READ && cnt_reg != '0) begin
               cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (capture) begin
               instr_reg <= mem.mem_rdata;
               pc_reg    <= pc_reg + ADDR_W'(1);
               if (&pc_reg) begin
                  wrap_reg <= 1'b1;
               end
            end
         end
      end
   end

   assign mem.mem_addr  = addr_reg;
   assign mem.mem_rd_en = rd_en_reg;

   // Decoded fields come only from the held word, never from mem_rdata directly.
   assign valid_instr   = (state_reg == HOLD);
   assign last_instr    = instr_reg[INSTR_W-1];
   assign use_v         = instr_reg[INSTR_W-2];
   assign v_gen_id      = instr_reg[INSTR_W-3];
   assign instr_payload = instr_reg[INSTR_W-4:0];
   assign pc            = pc_reg;
   assign pc_wrap       = wrap_reg;

endmodule

// File: tb/tb_instr_fetch_estu.sv
// Directed bench for instr_fetch_estu: three instances cover MEM_LAT=1,
// MEM_LAT=4 and ADDR_W=2, each with its own synchronous memory model.
module tb_instr_fetch_estu;

   logic clk;
   logic rst;
   logic fa, ca, fb, cb, fc, cc;

   int n_checks;
   int n_fail;

   // Instance a: MEM_LAT=1, ADDR_W=8
   instr_fetch_estu_if #(.INSTR_W(32), .ADDR_W(8)) ia ();
   logic        a_valid, a_last, a_use_v, a_vgen, a_wrap;
   logic [28:0] a_payload;
   logic [7:0]  a_pc;

   // Instance b: MEM_LAT=4, ADDR_W=8
   instr_fetch_estu_if #(.INSTR_W(32), .ADDR_W(8)) ib ();
   logic        b_valid, b_last, b_use_v, b_vgen, b_wrap;
   logic [28:0] b_payload;
   logic [7:0]  b_pc;

   // Instance c: MEM_LAT=1, ADDR_W=2
   instr_fetch_estu_if #(.INSTR_W(32), .ADDR_W(2)) ic ();
   logic        c_valid, c_last, c_use_v, c_vgen, c_wrap;
   logic [28:0] c_payload;
   logic [1:0]  c_pc;

   instr_fetch_estu #(.INSTR_W(32), .ADDR_W(8), .MEM_LAT(1)) u_a (
      .clk(clk), .rst(rst), .fetch_instr(fa), .clr_pc(ca), .mem(ia),
      .valid_instr(a_valid), .last_instr(a_last), .use_v(a_use_v), .v_gen_id(a_vgen),
      .instr_payload(a_payload), .pc(a_pc), .pc_wrap(a_wrap)
   );

   instr_fetch_estu #(.INSTR_W(32), .ADDR_W(8), .MEM_LAT(4)) u_b (
      .clk(clk), .rst(rst), .fetch_instr(fb), .clr_pc(cb), .mem(ib),
      .valid_instr(b_valid), .last_instr(b_last), .use_v(b_use_v), .v_gen_id(b_vgen),
      .instr_payload(b_payload), .pc(b_pc), .pc_wrap(b_wrap)
   );

   instr_fetch_estu #(.INSTR_W(32), .ADDR_W(2), .MEM_LAT(1)) u_c (
      .clk(clk), .rst(rst), .fetch_instr(fc), .clr_pc(cc), .mem(ic),
      .valid_instr(c_valid), .last_instr(c_last), .use_v(c_use_v), .v_gen_id(c_vgen),
      .instr_payload(c_payload), .pc(c_pc), .pc_wrap(c_wrap)
   );

   // Memory models: rd_en sampled on an edge, data presented MEM_LAT edges later.
   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];
   logic [31:0] mem_c [0:3];
   logic [31:0] pb0, pb1, pb2;

   always @(posedge clk) begin
      ia.mem_rdata <= ia.mem_rd_en ? mem_a[ia.mem_addr] : 32'h0;
      ic.mem_rdata <= ic.mem_rd_en ? mem_c[ic.mem_addr] : 32'h0;
      pb0          <= ib.mem_rd_en ? mem_b[ib.mem_addr] : 32'h0;
      pb1          <= pb0;
      pb2          <= pb1;
      ib.mem_rdata <= pb2;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [2:0]  exp_flags [0:2];
   logic [31:0] exp_pay   [0:2];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      fa = 1'b0; ca = 1'b0; fb = 1'b0; cb = 1'b0; fc = 1'b0; cc = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 32'h0;
         mem_b[i] = 32'h0;
      end
      mem_a[0] = 32'hA0000005;
      mem_b[0] = 32'h60000007;
      mem_c[0] = 32'h00000010;
      mem_c[1] = 32'h00000011;
      mem_c[2] = 32'h00000012;
      mem_c[3] = 32'h00000013;
      exp_flags[0] = 3'b100; exp_pay[0] = 32'h1;
      exp_flags[1] = 3'b010; exp_pay[1] = 32'h2;
      exp_flags[2] = 3'b001; exp_pay[2] = 32'h3;

      // Reset state
      tick(); tick();
      chk("rst_rd_en", 32'(ia.mem_rd_en), 32'h0);
      chk("rst_addr",  32'(ia.mem_addr),  32'h0);
      chk("rst_valid", 32'(a_valid),      32'h0);
      chk("rst_pc",    32'(a_pc),         32'h0);
      chk("rst_wrap",  32'(a_wrap),       32'h0);
      chk("rst_pay",   32'(a_payload),    32'h0);
      rst = 1'b1;
      tick();

      // Single fetch, MEM_LAT=1
      fa = 1'b1;
      tick();
      fa = 1'b0;
      $display("fetch a addr=%0h", ia.mem_addr);
      chk("t1_rd_en_e0", 32'(ia.mem_rd_en), 32'h1);
      chk("t1_addr_e0",  32'(ia.mem_addr),  32'h0);
      chk("t1_valid_e0", 32'(a_valid),      32'h0);
      tick();
      chk("t1_rd_en_e1", 32'(ia.mem_rd_en), 32'h0);
      chk("t1_valid_e1", 32'(a_valid),      32'h0);
      tick();
      chk("t1_valid_e2", 32'(a_valid),      32'h1);
      chk("t1_last",     32'(a_last),       32'h1);
      chk("t1_use_v",    32'(a_use_v),      32'h0);
      chk("t1_vgen",     32'(a_vgen),       32'h1);
      chk("t1_payload",  32'(a_payload),    32'h5);
      chk("t1_pc",       32'(a_pc),         32'h1);

      // Sequential program from a cleared PC
      mem_a[0] = 32'h40000001;
      mem_a[1] = 32'h20000002;
      mem_a[2] = 32'h80000003;
      mem_a[3] = 32'h12345678;
      ca = 1'b1;
      tick();
      ca = 1'b0;
      chk("t2_clr_pc",    32'(a_pc),    32'h0);
      chk("t2_clr_valid", 32'(a_valid), 32'h0);
      for (int i = 0; i < 3; i++) begin
         fa = 1'b1;
         tick();
         fa = 1'b0;
         $display("fetch a addr=%0h", ia.mem_addr);
         chk("t2_addr",      32'(ia.mem_addr), 32'(i));
         chk("t2_valid_low", 32'(a_valid),     32'h0);
         tick();
         tick();
         chk("t2_valid", 32'(a_valid), 32'h1);
         chk("t2_flags", 32'({a_use_v, a_vgen, a_last}), 32'(exp_flags[i]));
         chk("t2_pay",   32'(a_payload), exp_pay[i]);
         chk("t2_pc",    32'(a_pc), 32'(i + 1));
      end

      // MEM_LAT=4 latency and a fetch ignored during READ
      fb = 1'b1;
      tick();
      fb = 1'b0;
      $display("fetch b addr=%0h", ib.mem_addr);
      chk("t3_rd_en_e0", 32'(ib.mem_rd_en), 32'h1);
      chk("t3_addr_e0",  32'(ib.mem_addr),  32'h0);
      tick();
      chk("t3_rd_en_e1", 32'(ib.mem_rd_en), 32'h0);
      chk("t3_valid_e1", 32'(b_valid),      32'h0);
      fb = 1'b1;
      tick();
      fb = 1'b0;
      chk("t3_rd_en_e2", 32'(ib.mem_rd_en), 32'h0);
      chk("t3_valid_e2", 32'(b_valid),      32'h0);
      tick();
      chk("t3_valid_e3", 32'(b_valid), 32'h0);
      tick();
      chk("t3_valid_e4", 32'(b_valid), 32'h0);
      tick();
      chk("t3_valid_e5", 32'(b_valid),   32'h1);
      chk("t3_pc_e5",    32'(b_pc),      32'h1);
      chk("t3_payload",  32'(b_payload), 32'h7);
      chk("t3_flags",    32'({b_use_v, b_vgen, b_last}), 32'h6);
      tick();
      chk("t3_no_queue_rd", 32'(ib.mem_rd_en), 32'h0);
      chk("t3_pc_once",     32'(b_pc),         32'h1);

      // PC wrap with ADDR_W=2
      for (int i = 0; i < 4; i++) begin
         fc = 1'b1;
         tick();
         fc = 1'b0;
         $display("fetch c addr=%0h", ic.mem_addr);
         tick();
         tick();
         chk("t5_pc",   32'(c_pc),      32'((i + 1) % 4));
         chk("t5_wrap", 32'(c_wrap),    (i == 3) ? 32'h1 : 32'h0);
         chk("t5_pay",  32'(c_payload), 32'(16 + i));
      end
      cc = 1'b1;
      tick();
      cc = 1'b0;
      chk("t5_clr_wrap", 32'(c_wrap), 32'h0);
      chk("t5_clr_pc",   32'(c_pc),   32'h0);

      // Abort: clr_pc one cycle after the read strobe
      fa = 1'b1;
      tick();
      fa = 1'b0;
      $display("fetch a addr=%0h (aborted)", ia.mem_addr);
      chk("t4_rd_en", 32'(ia.mem_rd_en), 32'h1);
      chk("t4_addr",  32'(ia.mem_addr),  32'h3);
      ca = 1'b1;
      tick();
      ca = 1'b0;
      chk("t4_valid_e1", 32'(a_valid),      32'h0);
      chk("t4_pc_e1",    32'(a_pc),         32'h0);
      chk("t4_rd_en_e1", 32'(ia.mem_rd_en), 32'h0);
      tick();
      chk("t4_valid_e2", 32'(a_valid),   32'h0);
      chk("t4_pay_kept", 32'(a_payload), 32'h3);
      chk("t4_pc_e2",    32'(a_pc),      32'h0);
      tick();
      chk("t4_valid_e3", 32'(a_valid), 32'h0);
      fa = 1'b1;
      tick();
      fa = 1'b0;
      $display("fetch a addr=%0h", ia.mem_addr);
      chk("t4_refetch_addr", 32'(ia.mem_addr), 32'h0);
      tick();
      tick();
      chk("t4_refetch_pay", 32'(a_payload), 32'h1);
      chk("t4_refetch_pc",  32'(a_pc),      32'h1);

      // Asynchronous reset in the middle of a READ
      fa = 1'b1;
      tick();
      fa = 1'b0;
      $display("fetch a addr=%0h (reset mid-read)", ia.mem_addr);
      chk("t6_rd_en_pre", 32'(ia.mem_rd_en), 32'h1);
      chk("t6_addr_pre",  32'(ia.mem_addr),  32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rd_en",  32'(ia.mem_rd_en), 32'h0);
      chk("t6_addr",   32'(ia.mem_addr),  32'h0);
      chk("t6_valid",  32'(a_valid),      32'h0);
      chk("t6_pc",     32'(a_pc),         32'h0);
      chk("t6_wrap",   32'(a_wrap),       32'h0);
      chk("t6_flags",  32'({a_use_v, a_vgen, a_last}), 32'h0);
      chk("t6_pay",    32'(a_payload),    32'h0);
      tick();
      rst = 1'b1;
      tick();
      fa = 1'b1;
      tick();
      fa = 1'b0;
      $display("fetch a addr=%0h", ia.mem_addr);
      chk("t6_first_addr", 32'(ia.mem_addr), 32'h0);
      tick();
      tick();
      chk("t6_first_pay", 32'(a_payload), 32'h1);

      // Simultaneous clr_pc and fetch_instr
      ca = 1'b1;
      fa = 1'b1;
      tick();
      ca = 1'b0;
      fa = 1'b0;
      chk("t7_rd_en",  32'(ia.mem_rd_en), 32'h0);
      chk("t7_pc",     32'(a_pc),         32'h0);
      chk("t7_valid",  32'(a_valid),      32'h0);
      tick();
      chk("t7_rd_en2", 32'(ia.mem_rd_en), 32'h0);
      chk("t7_valid2", 32'(a_valid),      32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
